// File: rtl/leaf_out_arbiter.sv
// Round-robin merge of several user-kernel output streams onto one leaf output stream.
// Optional per-port word counters are built only when LEAF_ARB_STATS_EN is defined.

module leaf_arb_lane (
`ifdef LEAF_ARB_STATS_EN
  input  logic        clk_user,
  input  logic        reset_n,
  input  logic        vld,
  output logic [31:0] count,
`endif
  input  logic        granted,
  input  logic        ack_in,
  output logic        ack_out
);
  assign ack_out = granted & ack_in;

`ifdef LEAF_ARB_STATS_EN
  always_ff @(posedge clk_user or negedge reset_n)
    if (!reset_n)                   count <= '0;
    else if (granted & vld & ack_in) count <= count + 32'd1;
`endif
endmodule

module leaf_out_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int PORT_BITS    = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                              clk_user,
  input  logic                              reset_n,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_PORTS-1:0]              vld_user2arb,
  output logic [NUM_PORTS-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]           dout_arb2interface,
  output logic                              vld_arb2interface,
  input  logic                              ack_interface2arb,
  output logic [PORT_BITS-1:0]              grant_port,
  output logic                              busy
`ifdef LEAF_ARB_STATS_EN
  ,
  input  logic [PORT_BITS-1:0]              stat_sel,
  output logic [31:0]                       stat_count
`endif
);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                   state, state_nxt;
  logic [PORT_BITS-1:0]                     sel, sel_nxt, rr_ptr, rr_nxt, pick;
  logic [BCW-1:0]                           burst_cnt, burst_nxt;
  logic [NUM_PORTS-1:0][PAYLOAD_BITS-1:0]   din_arr;
  logic [NUM_PORTS-1:0]                     granted;
  logic                                     sel_vld, xfer, found;

  assign din_arr = din_user2arb;
  assign sel_vld = vld_user2arb[sel];
  assign xfer    = (state == GRANT) && sel_vld && ack_interface2arb;

  // First requester strictly after rr_ptr, then wrap to the ports at or below it.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && vld_user2arb[i] && i > int'(rr_ptr)) begin
        pick  = PORT_BITS'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && vld_user2arb[i] && i <= int'(rr_ptr)) begin
        pick  = PORT_BITS'(i);
        found = 1'b1;
      end
  end

  always_ff @(posedge clk_user or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= PORT_BITS'(NUM_PORTS - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE:
        if (|vld_user2arb) begin
          sel_nxt   = pick;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      GRANT:
        // A dropped valid or the last word of the burst releases the grant.
        if (!sel_vld || (xfer && burst_cnt == BCW'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          rr_nxt    = sel;
        end else if (xfer) begin
          burst_nxt = burst_cnt + BCW'(1);
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dout_arb2interface = '0;
    vld_arb2interface  = 1'b0;
    if (state == GRANT) begin
      dout_arb2interface = din_arr[sel];
      vld_arb2interface  = sel_vld;
    end
  end

  assign grant_port = sel;
  assign busy       = (state == GRANT);

`ifdef LEAF_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt;
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    assign granted[g] = (state == GRANT) && (sel == PORT_BITS'(g));
    leaf_arb_lane u_lane (
`ifdef LEAF_ARB_STATS_EN
      .clk_user (clk_user),
      .reset_n  (reset_n),
      .vld      (vld_user2arb[g]),
      .count    (cnt[g]),
`endif
      .granted  (granted[g]),
      .ack_in   (ack_interface2arb),
      .ack_out  (ack_arb2user[g])
    );
  end

`ifdef LEAF_ARB_STATS_EN
  always_ff @(posedge clk_user or negedge reset_n)
    if (!reset_n)                         stat_count <= '0;
    else if (int'(stat_sel) < NUM_PORTS)  stat_count <= cnt[stat_sel];
    else                                  stat_count <= '0;
`endif
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: per-port source models feed the DUT,
// a negedge monitor pops expected (port, data) pairs as words leave the arbiter.

module tb_leaf_out_arbiter;
  localparam int NP = 4;
  localparam int PB = 32;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
  } exp_t;

  logic                   clk_user = 1'b0;
  logic                   reset_n  = 1'b0;
  logic [NP-1:0][PB-1:0]  din      = '0;
  logic [NP-1:0]          vld      = '0;
  logic [NP-1:0]          ack_arb2user;
  logic [PB-1:0]          dout;
  logic                   vld_out;
  logic                   ack_in   = 1'b1;
  logic [1:0]             grant_port;
  logic                   busy;
`ifdef LEAF_ARB_STATS_EN
  logic [1:0]             stat_sel = '0;
  logic [31:0]            stat_count;
`endif

  leaf_out_arbiter #(.NUM_PORTS(NP), .PAYLOAD_BITS(PB), .PORT_BITS(2), .MAX_BURST(16)) dut (
    .clk_user           (clk_user),
    .reset_n            (reset_n),
    .din_user2arb       (din),
    .vld_user2arb       (vld),
    .ack_arb2user       (ack_arb2user),
    .dout_arb2interface (dout),
    .vld_arb2interface  (vld_out),
    .ack_interface2arb  (ack_in),
    .grant_port         (grant_port),
    .busy               (busy)
`ifdef LEAF_ARB_STATS_EN
    ,
    .stat_sel           (stat_sel),
    .stat_count         (stat_count)
`endif
  );

  always #5 clk_user = ~clk_user;

  int tests = 0, fails = 0;
  int cyc = 0, n_xfer = 0, cur_len = 0, idle_run = 0;
  logic prev_busy = 1'b0;
  logic [1:0] cur_port = '0;
  logic [NP-1:0] taken = '0;
  logic [31:0] mem [NP][256];
  int head [NP] = '{default: 0};
  int tail [NP] = '{default: 0};
  exp_t sb_q[$];
  exp_t mon_e;
  int len_q[$], gap_q[$], xcyc_q[$], fall_q[$];
  logic [1:0] lport_q[$];

  always @(posedge clk_user) cyc <= cyc + 1;

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      vld[i] = (head[i] != tail[i]);
      din[i] = (head[i] != tail[i]) ? mem[i][head[i]] : '0;
    end
  endtask

  // Source model: pop a word once the arbiter has acked it, present the next.
  always @(posedge clk_user) begin
    #1;
    for (int i = 0; i < NP; i++) if (taken[i]) head[i]++;
    refresh();
  end

  always @(negedge clk_user) begin
    for (int i = 0; i < NP; i++) taken[i] = vld[i] & ack_arb2user[i];
    if (vld_out === 1'b1 && ack_in === 1'b1) begin
      n_xfer++;
      cur_len++;
      xcyc_q.push_back(cyc);
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL xfer: unexpected word port %0d data %h", grant_port, dout);
      end else begin
        mon_e = sb_q.pop_front();
        if (grant_port !== mon_e.port || dout !== mon_e.data) begin
          fails++;
          $display("FAIL xfer: got port %0d data %h, expected port %0d data %h",
                   grant_port, dout, mon_e.port, mon_e.data);
        end
      end
    end
    if (busy === 1'b1 && !prev_busy) begin
      gap_q.push_back(idle_run);
      cur_port = grant_port;
    end
    if (busy !== 1'b1 && prev_busy) begin
      len_q.push_back(cur_len);
      lport_q.push_back(cur_port);
      fall_q.push_back(cyc);
      cur_len = 0;
    end
    if (busy !== 1'b1) idle_run++;
    else               idle_run = 0;
    prev_busy = (busy === 1'b1);
  end

  task automatic load(input int p, input logic [31:0] d, input bit expect_it);
    mem[p][tail[p]] = d;
    tail[p]++;
    if (expect_it) sb_q.push_back('{port: 2'(p), data: d});
  endtask

  task automatic expect_word(input int p, input logic [31:0] d);
    sb_q.push_back('{port: 2'(p), data: d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NP; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    len_q.delete(); gap_q.delete(); xcyc_q.delete(); fall_q.delete(); lport_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(busy === 1'b0 && sb_q.size() == 0 && srcs_empty()) && n < 3000) begin
      @(negedge clk_user);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL %s: timeout, busy=%b pending=%0d", tag, busy, sb_q.size());
    end
    @(posedge clk_user); #2;
  endtask

  task automatic wait_xfers(input int base, input int n, input string tag);
    int k = 0;
    while (n_xfer - base < n && k < 200) begin
      @(posedge clk_user); #2;
      k++;
    end
    if (k >= 200) begin
      tests++; fails++;
      $display("FAIL %s: got %0d words, required %0d", tag, n_xfer - base, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_user);
    @(negedge clk_user);
    tests++;
    if ({ack_arb2user, vld_out, dout, grant_port, busy} !== '0) begin
      fails++;
      $display("FAIL reset_hold: ack=%b vld=%b dout=%h grant=%0d busy=%b, required all 0",
               ack_arb2user, vld_out, dout, grant_port, busy);
    end
`ifdef LEAF_ARB_STATS_EN
    tests++;
    if (stat_count !== 32'd0) begin
      fails++; $display("FAIL reset_stat: got %0d required 0", stat_count);
    end
`endif
    @(posedge clk_user); #2;
    reset_n = 1'b1;
    repeat (2) @(negedge clk_user);
    tests++;
    if ({ack_arb2user, vld_out, dout, grant_port, busy} !== '0) begin
      fails++;
      $display("FAIL reset_idle: ack=%b vld=%b dout=%h grant=%0d busy=%b, required all 0",
               ack_arb2user, vld_out, dout, grant_port, busy);
    end
    @(posedge clk_user); #2;
  endtask

  task automatic test_rotation();
    int exp_len [5] = '{16, 16, 16, 16, 4};
    logic [1:0] exp_port [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    clear_logs();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < (p == 0 ? 20 : 16); k++) load(p, {8'(p + 1), 24'(k)}, 1'b0);
    for (int k = 0; k < 16; k++) expect_word(0, {8'd1, 24'(k)});
    for (int p = 1; p < NP; p++)
      for (int k = 0; k < 16; k++) expect_word(p, {8'(p + 1), 24'(k)});
    for (int k = 16; k < 20; k++) expect_word(0, {8'd1, 24'(k)});
    refresh();
    wait_idle("rotation");
    tests++;
    if (len_q.size() != 5 || gap_q.size() != 5) begin
      fails++;
      $display("FAIL rot_grants: got %0d grants, required 5", len_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (len_q[k] != exp_len[k] || lport_q[k] !== exp_port[k]) begin
          fails++;
          $display("FAIL rot_grant%0d: got port %0d len %0d, required port %0d len %0d",
                   k, lport_q[k], len_q[k], exp_port[k], exp_len[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        tests++;
        if (gap_q[k] != 1) begin
          fails++; $display("FAIL rot_bubble%0d: got %0d idle cycles, required 1", k, gap_q[k]);
        end
      end
    end
  endtask

  task automatic test_single_stream();
    int load_cyc;
    clear_logs();
    for (int k = 0; k < 5; k++) load(2, 32'hA0 + k, 1'b1);
    refresh();
    load_cyc = cyc;
    wait_idle("stream");
    tests++;
    if (xcyc_q.size() != 5 || len_q.size() != 1 || fall_q.size() != 1) begin
      fails++;
      $display("FAIL stream_count: got %0d words %0d grants, required 5 and 1", xcyc_q.size(), len_q.size());
    end else begin
      tests++;
      if (xcyc_q[0] - load_cyc != 1) begin
        fails++; $display("FAIL stream_latency: got %0d cycles, required 1", xcyc_q[0] - load_cyc);
      end
      tests++;
      if (xcyc_q[4] - xcyc_q[0] != 4 || lport_q[0] !== 2'd2) begin
        fails++;
        $display("FAIL stream_burst: got span %0d port %0d, required 4 and 2", xcyc_q[4] - xcyc_q[0], lport_q[0]);
      end
      tests++;
      if (fall_q[0] - xcyc_q[4] != 2) begin
        fails++; $display("FAIL stream_release: got %0d cycles, required 2", fall_q[0] - xcyc_q[4]);
      end
    end
  endtask

  task automatic test_stall();
    int base;
    logic [PB+NP+4-1:0] snap;
    clear_logs();
    base = n_xfer;
    for (int k = 0; k < 20; k++) load(1, 32'hB000 + k, 1'b1);
    refresh();
    wait_xfers(base, 5, "stall_pre");
    ack_in = 1'b0;
    #1;
    snap = {dout, vld_out, ack_arb2user, grant_port, busy};
    base = n_xfer;
    repeat (7) begin
      @(negedge clk_user);
      tests++;
      if ({dout, vld_out, ack_arb2user, grant_port, busy} !== snap || n_xfer != base) begin
        fails++;
        $display("FAIL stall_hold: got %h words %0d, required %h words 0",
                 {dout, vld_out, ack_arb2user, grant_port, busy}, n_xfer - base, snap);
      end
    end
    @(posedge clk_user); #2;
    ack_in = 1'b1;
    wait_idle("stall");
    tests++;
    if (len_q.size() != 2) begin
      fails++; $display("FAIL stall_grants: got %0d grants, required 2", len_q.size());
    end else if (len_q[0] != 16 || len_q[1] != 4) begin
      fails++; $display("FAIL stall_grants: got len %0d/%0d, required 16/4", len_q[0], len_q[1]);
    end
  endtask

  task automatic test_priority();
    load(3, 32'hF0, 1'b1); load(3, 32'hF1, 1'b1);
    refresh();
    wait_idle("prio_pre");
    clear_logs();
    load(0, 32'hC0, 1'b1); load(0, 32'hC1, 1'b1);
    load(3, 32'hC2, 1'b1); load(3, 32'hC3, 1'b1);
    refresh();
    wait_idle("prio");
    tests++;
    if (lport_q.size() != 2) begin
      fails++; $display("FAIL prio_order: got %0d grants, required 2", lport_q.size());
    end else if (lport_q[0] !== 2'd0 || lport_q[1] !== 2'd3) begin
      fails++; $display("FAIL prio_order: got %0d,%0d required 0,3", lport_q[0], lport_q[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int base = n_xfer;
    for (int k = 0; k < 3; k++) load(2, 32'hD0 + k, 1'b1);
    for (int k = 3; k < 8; k++) load(2, 32'hD0 + k, 1'b0);
    refresh();
    wait_xfers(base, 3, "rst_pre");
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({ack_arb2user, vld_out, dout, grant_port, busy} !== '0) begin
      fails++;
      $display("FAIL rst_async: ack=%b vld=%b dout=%h grant=%0d busy=%b, required all 0",
               ack_arb2user, vld_out, dout, grant_port, busy);
    end
    @(posedge clk_user); #2;
    clear_logs();
    load(0, 32'hE0, 1'b1); load(0, 32'hE1, 1'b1);
    for (int k = 3; k < 8; k++) expect_word(2, 32'hD0 + k);
    refresh();
    reset_n = 1'b1;
    wait_idle("rst_post");
    tests++;
    if (lport_q.size() != 2) begin
      fails++; $display("FAIL rst_prio: got %0d grants, required 2", lport_q.size());
    end else if (lport_q[0] !== 2'd0 || len_q[1] != 5) begin
      fails++; $display("FAIL rst_prio: got first port %0d, port2 len %0d, required 0 and 5", lport_q[0], len_q[1]);
    end
  endtask

`ifdef LEAF_ARB_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    @(posedge clk_user); #2;
    reset_n = 1'b1;
    for (int k = 0; k < 37; k++) load(1, 32'h5000 + k, 1'b1);
    refresh();
    wait_idle("stats");
    stat_sel = 2'd1;
    @(negedge clk_user);
    tests++;
    if (stat_count !== 32'd0) begin
      fails++; $display("FAIL stat_latency: got %0d, required 0 (port 0 still selected)", stat_count);
    end
    @(negedge clk_user);
    tests++;
    if (stat_count !== 32'd37) begin
      fails++; $display("FAIL stat_port1: got %0d, required 37", stat_count);
    end
    @(posedge clk_user); #2;
    stat_sel = 2'd0;
    @(posedge clk_user);
    @(negedge clk_user);
    tests++;
    if (stat_count !== 32'd0) begin
      fails++; $display("FAIL stat_port0: got %0d, required 0", stat_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_single_stream();
    test_stall();
    test_priority();
    test_reset_mid_burst();
`ifdef LEAF_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin arbiter that shares a leaf's single user-to-interface output stream among several user kernel output ports. It sits between the output ports of `user_kernel` (ap_vld/ap_ack style) and the `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` stream of `leaf_interface`. It lets one leaf carry several kernel outputs without extra interface ports. Each grant is held for a bounded burst of words so that no port can starve the others.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting user output ports (2..16).
- `PAYLOAD_BITS`, 32: data width per word.
- `PORT_BITS`, 2: index width; must equal clog2(`NUM_PORTS`).
- `MAX_BURST`, 16: maximum words transferred per grant (1..256).

Ports:
- `clk_user`  in  1: user clock; all state is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `din_user2arb`  in  NUM_PORTS*PAYLOAD_BITS: port i data in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- `vld_user2arb`  in  NUM_PORTS: per-port valid.
- `ack_arb2user`  out  NUM_PORTS: per-port acknowledge.
- `dout_arb2interface`  out  PAYLOAD_BITS: merged data to `leaf_interface`.
- `vld_arb2interface`  out  1: merged valid.
- `ack_interface2arb`  in  1: acknowledge from `leaf_interface`.
- `grant_port`  out  PORT_BITS: currently or last granted port.
- `busy`  out  1: high while in GRANT.
- `stat_sel`  in  PORT_BITS: counter select. Present only with `LEAF_ARB_STATS_EN`.
- `stat_count`  out  32: selected port's word count. Present only with `LEAF_ARB_STATS_EN`.

## Operation
- A word transfers on any cycle where valid and ack are both high on the same cycle.
- FSM states:
  - IDLE (reset state):
    - If any `vld_user2arb` bit is high, pick the first requester scanning from `rr_ptr+1` upward with wrap at `NUM_PORTS-1` → 0.
    - Register the choice in `sel`, load `burst_cnt`=0, and go to GRANT.
    - No transfer occurs in IDLE.
  - GRANT:
    - Datapath is combinational: `dout_arb2interface`=din[sel], `vld_arb2interface`=vld_user2arb[sel], `ack_arb2user[sel]`=`ack_interface2arb`.
    - All other ack bits are 0.
  - GRANT → IDLE when either of these holds:
    - a transfer occurs with `burst_cnt`==MAX_BURST-1;
    - `vld_user2arb[sel]`==0 on that cycle.
  - On leaving GRANT, `rr_ptr`<=`sel`. Otherwise `burst_cnt` increments on each transfer.
- When not in GRANT, `dout_arb2interface`=0 and `vld_arb2interface`=0.
- Ack low with vld high is a stall: state, `sel` and `burst_cnt` are held indefinitely.
- `grant_port`=`sel`; it holds its value through IDLE.
- Changes on non-selected inputs never affect the outputs or the current grant.
- `rr_ptr` resets to NUM_PORTS-1, so port 0 wins the first arbitration.

## Timing
- Reset values:
  - `ack_arb2user`=0, `vld_arb2interface`=0, `dout_arb2interface`=0.
  - `grant_port`=0, `busy`=0, `stat_count`=0.
- Request-to-first-transfer latency is 1 cycle: requests seen in IDLE at edge N put GRANT on the outputs in cycle N+1.
- Every grant release costs exactly one IDLE bubble cycle. Peak throughput is MAX_BURST/(MAX_BURST+1).
- `MAX_BURST`=1 forces re-arbitration after every word.
- `burst_cnt` is clog2(MAX_BURST)+1 bits wide and never wraps.
- When `reset_n` is asserted mid-burst, all outputs clear immediately (asynchronously). The in-flight word is not transferred.

## Configuration
- With `LEAF_ARB_STATS_EN` defined:
  - Add one 32-bit counter per port; it increments on each transfer from that port and wraps 0xFFFFFFFF → 0.
  - Counters are cleared only by reset.
  - `stat_count` is the registered counter[stat_sel] (1-cycle read latency).
  - `stat_sel` ≥ NUM_PORTS returns 0.
- Without it, the `stat_sel` and `stat_count` ports and all counter logic are absent; arbitration behaviour is identical.

## Test plan
- Reset, then port 2 alone streams 5 words 0xA0..0xA4 with ack tied high:
  - IDLE 1 cycle, then 5 consecutive transfers and `grant_port`=2;
  - vld drop → IDLE.
- All 4 ports continuously valid, ack high, MAX_BURST=16:
  - grants rotate 0,1,2,3,0;
  - each grant carries exactly 16 words, with exactly one bubble between grants.
- Port 1 granted, ack low for 7 cycles mid-burst:
  - outputs and `ack_arb2user` are held stable;
  - `burst_cnt` does not advance;
  - the burst resumes and ends after 16 total words.
- Ports 0 and 3 request simultaneously after a port 3 grant ended: port 0 wins; the next grant goes to port 3.
- `reset_n` pulsed low during word 4 of a burst:
  - all outputs are 0 within the same cycle;
  - after release, port 0 has first priority.
- With `LEAF_ARB_STATS_EN`, after 37 words from port 1: `stat_sel`=1 reads 37 one cycle later, `stat_sel`=0 reads 0.
